// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle: pipeline register contents in, write/stall/flush controls out.
interface pipeline_hazard_ctrl_if;
   logic [3:0]  ifid_opcode;
   logic [1:0]  ifid_ra;
   logic [1:0]  ifid_rb;
   logic        ifid_valid;
   logic [3:0]  idex_opcode;
   logic [1:0]  idex_ra;
   logic        idex_valid;
   logic        branch_taken_ex;
   logic        mem_busy;
   logic        resume;
   logic        pc_write;
   logic        ifid_write;
   logic        ifid_flush;
   logic        idex_stall;
   logic        idex_flush;
   logic        pipe_freeze;
   logic        halted;
   logic [15:0] stall_cycles;
   logic [7:0]  flush_count;

   modport master (
      output ifid_opcode, ifid_ra, ifid_rb, ifid_valid,
      output idex_opcode, idex_ra, idex_valid,
      output branch_taken_ex, mem_busy, resume,
      input  pc_write, ifid_write, ifid_flush, idex_stall,
      input  idex_flush, pipe_freeze, halted,
      input  stall_cycles, flush_count
   );

   modport slave (
      input  ifid_opcode, ifid_ra, ifid_rb, ifid_valid,
      input  idex_opcode, idex_ra, idex_valid,
      input  branch_taken_ex, mem_busy, resume,
      output pc_write, ifid_write, ifid_flush, idex_stall,
      output idex_flush, pipe_freeze, halted,
      output stall_cycles, flush_count
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use / branch / mem-wait / halt control for the 8-bit pipeline.
// Optional stall and redirect counters under `HAZARD_STATS_EN.
module pipeline_hazard_ctrl #(
   parameter logic [3:0] OP_LOAD      = 4'h8,
   parameter logic [3:0] OP_HALT      = 4'hF,
   parameter int         FLUSH_CYCLES = 1
) (
   input logic                 clk,
   input logic                 reset,
   pipeline_hazard_ctrl_if.slave bus
);

   typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT, HALT} state_t;

   localparam logic [2:0] FRELOAD = 3'(FLUSH_CYCLES - 1);
   localparam bit         MULTI   = (FLUSH_CYCLES > 1);

   state_t     state, state_n;
   logic [2:0] fcnt, fcnt_n;
   logic       br_acc;
   logic       lu, is_halt;
   logic       pc_w, ifid_w, ifid_f, idex_s, idex_f, freeze, hlt;

   assign lu = bus.idex_valid & bus.ifid_valid &
               (bus.idex_opcode == OP_LOAD) &
               ((bus.idex_ra == bus.ifid_ra) |
                (bus.idex_ra == bus.ifid_rb));

   assign is_halt = bus.ifid_valid & (bus.ifid_opcode == OP_HALT);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= RUN;
         fcnt  <= '0;
      end else begin
         state <= state_n;
         fcnt  <= fcnt_n;
      end
   end

   always_comb begin
      state_n = state;
      fcnt_n  = fcnt;
      br_acc  = 1'b0;
      unique case (state)
         RUN, MEM_WAIT: begin
            if (bus.mem_busy) begin
               state_n = MEM_WAIT;
            end else if (bus.branch_taken_ex) begin
               br_acc = 1'b1;
               if (MULTI) begin
                  state_n = FLUSH;
                  fcnt_n  = FRELOAD;
               end else begin
                  state_n = RUN;
               end
            end else if (lu) begin
               state_n = RUN;
            end else if (is_halt) begin
               state_n = HALT;
            end else begin
               state_n = RUN;
            end
         end
         FLUSH: begin
            if (bus.mem_busy) begin
               state_n = FLUSH;
            end else if (bus.branch_taken_ex) begin
               br_acc = 1'b1;
               fcnt_n = FRELOAD;
            end else if (fcnt <= 3'd1) begin
               state_n = RUN;
               fcnt_n  = '0;
            end else begin
               fcnt_n = fcnt - 3'd1;
            end
         end
         HALT: begin
            if (bus.resume) state_n = RUN;
         end
         default: begin
            state_n = RUN;
            fcnt_n  = '0;
         end
      endcase
   end

   always_comb begin
      pc_w   = 1'b1;
      ifid_w = 1'b1;
      ifid_f = 1'b0;
      idex_s = 1'b0;
      idex_f = 1'b0;
      freeze = 1'b0;
      hlt    = 1'b0;
      if (reset) begin
         pc_w   = 1'b0;
         ifid_w = 1'b0;
         ifid_f = 1'b1;
         idex_f = 1'b1;
      end else begin
         unique case (state)
            RUN, MEM_WAIT: begin
               if (bus.mem_busy) begin
                  pc_w   = 1'b0;
                  ifid_w = 1'b0;
                  freeze = 1'b1;
               end else if (bus.branch_taken_ex) begin
                  ifid_f = 1'b1;
                  idex_f = 1'b1;
               end else if (lu) begin
                  pc_w   = 1'b0;
                  ifid_w = 1'b0;
                  idex_s = 1'b1;
               end
            end
            FLUSH: begin
               if (bus.mem_busy) begin
                  pc_w   = 1'b0;
                  ifid_w = 1'b0;
                  freeze = 1'b1;
               end else begin
                  ifid_f = 1'b1;
                  idex_f = bus.branch_taken_ex;
               end
            end
            HALT: begin
               pc_w   = 1'b0;
               ifid_w = 1'b0;
               idex_s = 1'b1;
               hlt    = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.pc_write    = pc_w;
   assign bus.ifid_write  = ifid_w;
   assign bus.ifid_flush  = ifid_f;
   assign bus.idex_stall  = idex_s;
   assign bus.idex_flush  = idex_f;
   assign bus.pipe_freeze = freeze;
   assign bus.halted      = hlt;

`ifdef HAZARD_STATS_EN
   logic [15:0] stall_q;
   logic [7:0]  flush_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         if (!pc_w && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
         if (br_acc && flush_q != 8'hFF)   flush_q <= flush_q + 8'd1;
      end
   end

   assign bus.stall_cycles = stall_q;
   assign bus.flush_count  = flush_q;
`else
   logic unused_br;
   assign unused_br        = br_acc;
   assign bus.stall_cycles = '0;
   assign bus.flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (FLUSH_CYCLES=3).
// Control vector: {pc_write,ifid_write,ifid_flush,idex_stall,idex_flush,pipe_freeze,halted}.
module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_STATS_EN
   localparam bit FEAT = 1'b1;
`else
   localparam bit FEAT = 1'b0;
`endif

   localparam logic [6:0] C_RST    = 7'b0010100;
   localparam logic [6:0] C_IDLE   = 7'b1100000;
   localparam logic [6:0] C_STALL  = 7'b0001000;
   localparam logic [6:0] C_FREEZE = 7'b0000010;
   localparam logic [6:0] C_BR     = 7'b1110100;
   localparam logic [6:0] C_FL     = 7'b1110000;
   localparam logic [6:0] C_HLT    = 7'b0001001;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   pipeline_hazard_ctrl_if bus ();

   pipeline_hazard_ctrl #(.FLUSH_CYCLES(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [6:0] ctl();
      return {bus.pc_write, bus.ifid_write, bus.ifid_flush,
              bus.idex_stall, bus.idex_flush, bus.pipe_freeze,
              bus.halted};
   endfunction

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_in();
      bus.ifid_opcode     = '0;
      bus.ifid_ra         = '0;
      bus.ifid_rb         = '0;
      bus.ifid_valid      = 1'b0;
      bus.idex_opcode     = '0;
      bus.idex_ra         = '0;
      bus.idex_valid      = 1'b0;
      bus.branch_taken_ex = 1'b0;
      bus.mem_busy        = 1'b0;
      bus.resume          = 1'b0;
   endtask

   task automatic do_reset();
      clear_in();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      clear_in();
      reset = 1'b1;

      // 1: reset and idle
      @(negedge clk);
      #1 check("rst_c0", 32'(ctl()), 32'(C_RST));
      @(negedge clk);
      #1 check("rst_c1", 32'(ctl()), 32'(C_RST));
      check("rst_stall", 32'(bus.stall_cycles), 32'd0);
      check("rst_flcnt", 32'(bus.flush_count), 32'd0);
      reset = 1'b0;
      #1 check("idle", 32'(ctl()), 32'(C_IDLE));

      // 2: load-use on rb, then bubble, then no-match, then ra match
      do_reset();
      bus.idex_opcode = 4'h8;
      bus.idex_ra     = 2'd2;
      bus.idex_valid  = 1'b1;
      bus.ifid_ra     = 2'd0;
      bus.ifid_rb     = 2'd2;
      bus.ifid_valid  = 1'b1;
      #1 check("lu_rb", 32'(ctl()), 32'(C_STALL));
      @(negedge clk);
      bus.idex_valid = 1'b0;
      #1 check("lu_bubble", 32'(ctl()), 32'(C_IDLE));
      @(negedge clk);
      bus.idex_valid = 1'b1;
      bus.idex_ra    = 2'd1;
      bus.ifid_ra    = 2'd0;
      bus.ifid_rb    = 2'd3;
      #1 check("lu_nomatch", 32'(ctl()), 32'(C_IDLE));
      @(negedge clk);
      bus.idex_ra = 2'd0;
      #1 check("lu_ra", 32'(ctl()), 32'(C_STALL));
      @(negedge clk);
      bus.idex_opcode = 4'h3;
      #1 check("lu_notload", 32'(ctl()), 32'(C_IDLE));
      check("lu_stalls", 32'(bus.stall_cycles), FEAT ? 32'd2 : 32'd0);

      // 3: taken branch, three flush cycles
      do_reset();
      bus.branch_taken_ex = 1'b1;
      #1 check("br_c0", 32'(ctl()), 32'(C_BR));
      @(negedge clk);
      bus.branch_taken_ex = 1'b0;
      #1 check("br_c1", 32'(ctl()), 32'(C_FL));
      @(negedge clk);
      #1 check("br_c2", 32'(ctl()), 32'(C_FL));
      @(negedge clk);
      #1 check("br_done", 32'(ctl()), 32'(C_IDLE));
      check("br_flcnt", 32'(bus.flush_count), FEAT ? 32'd1 : 32'd0);

      // 3b: mem_busy inside FLUSH holds the flush count
      do_reset();
      bus.branch_taken_ex = 1'b1;
      @(negedge clk);
      bus.branch_taken_ex = 1'b0;
      bus.mem_busy        = 1'b1;
      #1 check("flbusy_frz", 32'(ctl()), 32'(C_FREEZE));
      @(negedge clk);
      bus.mem_busy = 1'b0;
      #1 check("flbusy_c1", 32'(ctl()), 32'(C_FL));
      @(negedge clk);
      #1 check("flbusy_c2", 32'(ctl()), 32'(C_FL));
      @(negedge clk);
      #1 check("flbusy_done", 32'(ctl()), 32'(C_IDLE));

      // 3c: second branch in FLUSH reloads the counter
      do_reset();
      bus.branch_taken_ex = 1'b1;
      @(negedge clk);
      #1 check("flbr_c1", 32'(ctl()), 32'(C_BR));
      @(negedge clk);
      bus.branch_taken_ex = 1'b0;
      #1 check("flbr_c2", 32'(ctl()), 32'(C_FL));
      @(negedge clk);
      #1 check("flbr_c3", 32'(ctl()), 32'(C_FL));
      @(negedge clk);
      #1 check("flbr_done", 32'(ctl()), 32'(C_IDLE));
      check("flbr_flcnt", 32'(bus.flush_count), FEAT ? 32'd2 : 32'd0);

      // 4: mem_busy 4 cycles with a pending branch
      do_reset();
      bus.mem_busy        = 1'b1;
      bus.branch_taken_ex = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1 check($sformatf("mw_frz%0d", i), 32'(ctl()), 32'(C_FREEZE));
         @(negedge clk);
      end
      bus.mem_busy = 1'b0;
      #1 check("mw_br", 32'(ctl()), 32'(C_BR));
      @(negedge clk);
      bus.branch_taken_ex = 1'b0;
      check("mw_stalls", 32'(bus.stall_cycles), FEAT ? 32'd4 : 32'd0);
      #1 check("mw_fl1", 32'(ctl()), 32'(C_FL));
      @(negedge clk);
      #1 check("mw_fl2", 32'(ctl()), 32'(C_FL));
      @(negedge clk);
      #1 check("mw_done", 32'(ctl()), 32'(C_IDLE));
      check("mw_flcnt", 32'(bus.flush_count), FEAT ? 32'd1 : 32'd0);

      // 5: halt, 10 cycles, resume
      do_reset();
      bus.ifid_opcode = 4'hF;
      bus.ifid_valid  = 1'b1;
      #1 check("hlt_enter", 32'(ctl()), 32'(C_IDLE));
      @(negedge clk);
      clear_in();
      bus.branch_taken_ex = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1 check($sformatf("hlt_c%0d", i), 32'(ctl()), 32'(C_HLT));
         @(negedge clk);
      end
      bus.branch_taken_ex = 1'b0;
      bus.resume          = 1'b1;
      #1 check("hlt_resume", 32'(ctl()), 32'(C_HLT));
      @(negedge clk);
      bus.resume = 1'b0;
      #1 check("hlt_run", 32'(ctl()), 32'(C_IDLE));
      check("hlt_stalls", 32'(bus.stall_cycles), FEAT ? 32'd11 : 32'd0);
      check("hlt_flcnt", 32'(bus.flush_count), 32'd0);

      // 6: reset while in FLUSH with fcnt=2
      do_reset();
      bus.branch_taken_ex = 1'b1;
      @(negedge clk);
      bus.branch_taken_ex = 1'b0;
      #1 check("rf_fl", 32'(ctl()), 32'(C_FL));
      check("rf_flcnt_pre", 32'(bus.flush_count), FEAT ? 32'd1 : 32'd0);
      reset = 1'b1;
      #1 check("rf_rst", 32'(ctl()), 32'(C_RST));
      @(negedge clk);
      reset = 1'b0;
      #1 check("rf_idle", 32'(ctl()), 32'(C_IDLE));
      check("rf_flcnt", 32'(bus.flush_count), 32'd0);
      check("rf_stalls", 32'(bus.stall_cycles), 32'd0);
      @(negedge clk);
      #1 check("rf_idle2", 32'(ctl()), 32'(C_IDLE));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Pipeline control unit for the 8-bit Harvard pipeline. It detects load-use hazards, branch redirects, data-memory wait and HALT, and sequences the PC, IF/ID and ID/EX registers by driving their write, stall (bubble) and flush controls. The hazard decision is combinational, from the IF/ID and ID/EX contents. Multi-cycle behaviour (extra flush cycles, memory wait, halt) comes from a small registered FSM with counters.

Parameters:
OP_LOAD, 4'h8, opcode of the load instruction (the load-use producer)
OP_HALT, 4'hF, opcode of the halt instruction
FLUSH_CYCLES, 1, number of cycles IF/ID is flushed after a taken branch (1..7)

Ports:
clk  input  1  system clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset
ifid_opcode  input  4  opcode held in IF/ID
ifid_ra  input  2  ra field held in IF/ID
ifid_rb  input  2  rb field held in IF/ID
ifid_valid  input  1  IF/ID holds a real instruction
idex_opcode  input  4  opcode held in ID/EX
idex_ra  input  2  destination ra held in ID/EX
idex_valid  input  1  ID/EX holds a real instruction
branch_taken_ex  input  1  branch resolved taken in EX this cycle
mem_busy  input  1  data memory cannot complete this cycle
resume  input  1  leave HALT (level; sampled in HALT only)
pc_write  output  1  PC may update
ifid_write  output  1  IF/ID may load
ifid_flush  output  1  clear IF/ID to NOP
idex_stall  output  1  load a bubble into ID/EX
idex_flush  output  1  clear ID/EX entirely
pipe_freeze  output  1  hold EX/MEM/WB stages
halted  output  1  FSM is in HALT
stall_cycles  output  16  saturating count of stalled cycles (feature)
flush_count  output  8  saturating count of taken-branch redirects (feature)

Behaviour:
- State (registered): RUN, FLUSH, MEM_WAIT, HALT. Also a 3-bit flush counter fcnt. Reset -> RUN, fcnt=0.
- Outputs are combinational from state and inputs.
- While reset=1: pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, idex_stall=0, pipe_freeze=0, halted=0.
- Idle (RUN, no event): pc_write=1, ifid_write=1, all other control outputs 0.
- Hazard term lu = idex_valid & ifid_valid & (idex_opcode==OP_LOAD) & (idex_ra==ifid_ra | idex_ra==ifid_rb). The rb field is always compared (conservative).
- RUN events are evaluated in this priority order; only the first that applies acts:
  1. mem_busy: pc_write=0, ifid_write=0, pipe_freeze=1. Next state MEM_WAIT. branch_taken_ex is ignored (EX holds it and re-presents it later).
  2. branch_taken_ex: pc_write=1, ifid_flush=1, idex_flush=1. If FLUSH_CYCLES>1, next state FLUSH with fcnt=FLUSH_CYCLES-1; otherwise stay in RUN.
  3. lu: pc_write=0, ifid_write=0, idex_stall=1 for this cycle only. Stay in RUN; the next cycle re-evaluates with the bubble in ID/EX.
  4. ifid_valid & ifid_opcode==OP_HALT: the HALT passes into ID/EX (idle outputs), and next state is HALT.
- MEM_WAIT: pc_write=0, ifid_write=0, pipe_freeze=1 while mem_busy=1. When mem_busy=0, the cycle behaves exactly as RUN (same priority list) and the state leaves MEM_WAIT.
- FLUSH: pc_write=1, ifid_write=1, ifid_flush=1.
  - fcnt decrements each cycle; when fcnt reaches 1, next state is RUN.
  - mem_busy in FLUSH: freeze as above, fcnt holds, state stays FLUSH.
  - branch_taken_ex in FLUSH: also assert idex_flush and reload fcnt=FLUSH_CYCLES-1.
- HALT: pc_write=0, ifid_write=0, idex_stall=1, halted=1.
  - resume=1 gives next state RUN, and halted drops the cycle after.
  - All other inputs are ignored in HALT.
- Reset asserted mid-operation (any state) returns the FSM to RUN on the next edge. The feature counters clear.

Optional Feature:
HAZARD_STATS_EN
- Defined: stall_cycles increments, saturating at 16'hFFFF, in every non-reset cycle with pc_write=0. flush_count increments, saturating at 8'hFF, once per accepted branch_taken_ex. Both counters reset to 0.
- Undefined: no counter logic is built, and stall_cycles/flush_count are tied to 0.

Test Plan:
1. Reset held 2 cycles then released, no events -> during reset ifid_flush=1, idex_flush=1, pc_write=0; after release pc_write=1, ifid_write=1, all else 0, halted=0.
2. Load-use: idex_opcode=4'h8, idex_ra=2, idex_valid=1; ifid_rb=2, ifid_valid=1 -> exactly one cycle of idex_stall=1, pc_write=0; next cycle idex_valid=0 and pc_write=1. Same stimulus with idex_ra=1, ifid_ra=0, ifid_rb=3 -> no stall.
3. FLUSH_CYCLES=3, branch_taken_ex pulse -> idex_flush=1 for 1 cycle; ifid_flush=1 for 3 consecutive cycles; pc_write=1 throughout; flush_count=1 (feature on).
4. mem_busy=1 for 4 cycles coincident with branch_taken_ex=1 -> pc_write=0, pipe_freeze=1 for 4 cycles with no flush; on the first non-busy cycle the branch flushes; stall_cycles=4.
5. Opcode 4'hF in IF/ID -> halted=1 from the next cycle, pc_write=0, idex_stall=1; resume held 1 cycle after 10 cycles -> RUN, pc_write=1; stall_cycles=11 (10 in HALT + the resume cycle).
6. Reset asserted while in FLUSH with fcnt=2 -> next cycle state RUN, counters 0, idle outputs.
